photo_tape_transport: RTL and testbench
=======================================

# photo_tape_transport

Parametrised photoelectric tape reader transport. It is the successor to `tape_reader`, generalised in frame width and tape length, with a loadable tape image, bidirectional stepping, high-speed rewind and end-of-tape/beginning-of-tape detection. It sits between the typewriter/IO control (forward, reverse and rewind commands; wait-for-tape status) and the `timer` block's `tick_ms` pulse, and it drives the photo-cell frame lines.

## Interface
Parameters:
- `DATA_W`, default 5: frame width in photo channels.
- `DEPTH`, default 1024: tape capacity in frames; `AW = $clog2(DEPTH+1)`.
- `START_MS`, default 10: motor start delay in ms ticks.
- `FRAME_MS`, default 4: ms ticks per frame in forward and reverse run (250 char/s).
- `REWIND_MS`, default 1: ms ticks per frame during rewind.

Ports:
- `clk`  in  1: system clock. Single clock domain.
- `rst`  in  1: reset; synchronous, active-high.
- `tick_ms`  in  1: one-cycle pulse every ms, from `timer`.
- `load_we`  in  1: write `load_data` to the tape image at `load_addr`.
- `load_addr`  in  AW: tape image address, 0..DEPTH-1.
- `load_data`  in  DATA_W: frame data to write.
- `load_len_we`  in  1: set tape length to `load_len`.
- `load_len`  in  AW: number of valid frames, 0..DEPTH.
- `fwd`  in  1: forward relay command (RY-A), level.
- `rev`  in  1: reverse relay command (RY-B), level.
- `remote_rewind`  in  1: remote rewind, level; overrides `sw_rewind`.
- `sw_rewind`  in  1: front-panel rewind, level.
- `sw_forward`  in  1: front-panel forward, level.
- `photo`  out  DATA_W: frame under the read head.
- `frame_strobe`  out  1: one-cycle pulse when `photo` is updated with a new frame.
- `wait_for_tape`  out  1: high in START, RUN_FWD and RUN_REV.
- `tape_run`  out  1: motor running; high in START, RUN_FWD, RUN_REV and REWIND.
- `at_bot`  out  1: `pos == 0`.
- `at_eot`  out  1: `pos == len`.
- `pos`  out  AW: head position, in frames.

## Operation
**Tape image and length**
- The tape image is a DEPTH×DATA_W synchronous RAM.
- `load_we` and `load_len_we` take effect only in IDLE; they are ignored in all other states.
- If `load_len > DEPTH`, the length is clamped to DEPTH.
- Neither the RAM nor `len` is cleared by `rst`.

**Command decode** (registered each cycle, priority high to low)
- `remote_rewind` → REWIND.
- `sw_rewind` → REWIND.
- `fwd & rev` both high → none.
- `rev` → REV.
- `fwd | sw_forward` → FWD.

**States**
- IDLE
  - FWD or REV command → START. The tick counter is cleared and the direction latched.
  - REWIND command with `pos > 0` → REWIND.
- START
  - After START_MS ticks → RUN_FWD or RUN_REV, with the tick counter cleared.
  - Command dropped or changed → IDLE.
- RUN_FWD
  - Every FRAME_MS ticks, if `pos < len`: read `mem[pos]`, then increment `pos`.
  - If `pos == len`: no read and no strobe. The state stays RUN_FWD and `wait_for_tape` stays high.
- RUN_REV
  - Every FRAME_MS ticks, if `pos > 0`: decrement `pos`, then read `mem[pos-1]`.
  - If `pos == 0`: no read and no strobe. The state stays RUN_REV.
- REWIND
  - Every REWIND_MS ticks, decrement `pos`. No read, no strobe; `photo` is unchanged.
  - Reaching `pos == 0` → IDLE. The state stays in IDLE while the rewind command remains asserted.
- Leaving the current command in any RUN or REWIND state → IDLE on the next cycle. `pos` is held.

**Outputs**
- `photo` holds the last frame read until the next read or `rst`.
- Reset values: `photo = 0`, `frame_strobe = 0`, `wait_for_tape = 0`, `tape_run = 0`, `pos = 0`, state IDLE.
- Because `pos = 0` after reset, `at_bot = 1`, and `at_eot = (len == 0)`.

## Timing
- The command input is sampled at cycle C; the state changes at C+1.
- The first frame is read START_MS + FRAME_MS ticks after entering START. Later frames follow every FRAME_MS ticks.
- Frame timing, where the completing `tick_ms` is at cycle T:
  - `pos` updates at T+1.
  - The RAM read is issued at T+1.
  - `photo` and `frame_strobe` are valid at T+2.
- Status outputs are registered and change at the same cycle as the state or `pos` change.
- A tick coinciding with a command drop is ignored: no frame is read.
- `rst` mid-operation:
  - Outputs return to their reset values at the next edge.
  - Any pending strobe is cancelled.
- A `load_we` in the same cycle as an IDLE→START transition is accepted.

## Test plan
Configuration for all scenarios: DATA_W=5, DEPTH=16, START_MS=10, FRAME_MS=4, REWIND_MS=1. The tape is loaded with frames 0x01..0x08 and `len` = 8.

1. **Forward run to end of tape.** Assert `fwd`.
   - The first strobe comes 14 ticks later with `photo = 0x01`; strobes then repeat every 4 ticks up to 0x08.
   - Afterwards: `at_eot = 1`, `pos = 8`, no further strobes, `wait_for_tape = 1`, `tape_run = 1`.
2. **Reverse run from end of tape.** Start at `pos = 8` and assert `rev`.
   - After 14 ticks `photo = 0x08` and `pos = 7`.
   - 8 strobes occur, down to 0x01; then `at_bot = 1` and strobes stop.
3. **Rewind.** From `pos = 8`, assert `sw_rewind`.
   - `pos` decreases by 1 per tick with no strobes.
   - After 8 ticks: `at_bot = 1`, `tape_run = 0`, state IDLE.
4. **Priority and conflicts.**
   - `remote_rewind` with `sw_forward` → rewind wins.
   - `fwd` with `rev` → IDLE, `tape_run = 0`.
   - `load_we` during RUN_FWD → RAM unchanged.
5. **Stop and restart.**
   - Drop `fwd` after 3 frames → `pos = 3` held, `tape_run = 0` one cycle later.
   - Re-assert `fwd` → a 14-tick delay, then `photo = 0x04`.
6. **Reset mid-run.** Assert `rst` at `pos = 5` during RUN_FWD.
   - All outputs take their reset values and `pos = 0`.
   - Asserting `fwd` again yields `photo = 0x01`, confirming that the image and `len` are retained.

Source files
------------

// File: rtl/photo_tape_transport.sv
// Photoelectric tape reader transport: loadable tape image, forward/reverse stepping, rewind, BOT/EOT status.
// Latency: command sampled at cycle C moves the state at C+1; frame tick at T gives pos at T+1 and photo/frame_strobe at T+2.
// Backpressure: none. Motion is paced only by tick_ms, and dropping the command stops the tape on the next cycle.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   tick_ms                       1 ms pulse from the timer block
//   load_we/load_addr/load_data   tape image write port (honoured in IDLE only)
//   load_len_we/load_len          tape length write (honoured in IDLE only, clamped to DEPTH)
//   fwd, rev                      relay direction commands (levels)
//   remote_rewind, sw_rewind      rewind requests (levels); remote has priority
//   sw_forward                    front-panel forward (level)
//   photo, frame_strobe           frame under the head, one-cycle pulse on each new frame
//   wait_for_tape, tape_run       motor status
//   at_bot, at_eot, pos           head position and end markers
module photo_tape_transport #(
    parameter int DATA_W    = 5,
    parameter int DEPTH     = 1024,
    parameter int START_MS  = 10,
    parameter int FRAME_MS  = 4,
    parameter int REWIND_MS = 1,
    localparam int AW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_ms,
    input  logic              load_we,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_len_we,
    input  logic [AW-1:0]     load_len,
    input  logic              fwd,
    input  logic              rev,
    input  logic              remote_rewind,
    input  logic              sw_rewind,
    input  logic              sw_forward,
    output logic [DATA_W-1:0] photo,
    output logic              frame_strobe,
    output logic              wait_for_tape,
    output logic              tape_run,
    output logic              at_bot,
    output logic              at_eot,
    output logic [AW-1:0]     pos
);

    // RAM index width; the image needs at least two frames.
    localparam int IW = $clog2(DEPTH);

    localparam int MAX_MS = (START_MS > FRAME_MS)
                          ? ((START_MS > REWIND_MS) ? START_MS : REWIND_MS)
                          : ((FRAME_MS > REWIND_MS) ? FRAME_MS : REWIND_MS);
    localparam int CW     = $clog2(MAX_MS + 1);

    localparam logic [CW-1:0] START_LAST  = CW'(START_MS - 1);
    localparam logic [CW-1:0] FRAME_LAST  = CW'(FRAME_MS - 1);
    localparam logic [CW-1:0] REWIND_LAST = CW'(REWIND_MS - 1);
    localparam logic [AW-1:0] DEPTH_A     = AW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN_FWD,
        S_RUN_REV,
        S_REWIND
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_FWD,
        CMD_REV,
        CMD_REWIND
    } cmd_t;

    state_t              state_q;
    cmd_t                cmd_d;
    cmd_t                dir_q;
    logic [CW-1:0]       cnt_q;
    logic [AW-1:0]       pos_q;
    logic [AW-1:0]       pos_dec;
    logic [AW-1:0]       len_q;
    logic [AW-1:0]       len_d;
    logic                rd_pend_q;
    logic [IW-1:0]       rd_addr_q;
    logic [DATA_W-1:0]   photo_q;
    logic                strobe_q;
    logic                wft_q;
    logic                run_q;
    logic                idle_w;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Command decode, highest priority first. fwd together with rev is a
    // relay conflict and means "stop".
    always_comb begin
        cmd_d = CMD_NONE;
        if (remote_rewind || sw_rewind) begin
            cmd_d = CMD_REWIND;
        end else if (fwd && rev) begin
            cmd_d = CMD_NONE;
        end else if (rev) begin
            cmd_d = CMD_REV;
        end else if (fwd || sw_forward) begin
            cmd_d = CMD_FWD;
        end
    end

    assign len_d   = (load_len > DEPTH_A) ? DEPTH_A : load_len;
    assign pos_dec = pos_q - 1'b1;
    assign idle_w  = (state_q == S_IDLE);

    // Tape image and length are not touched by rst so a reset does not
    // lose the loaded tape. Writes are only accepted while the tape is stopped.
    always_ff @(posedge clk) begin
        if (idle_w) begin
            if (load_we && (load_addr < DEPTH_A)) begin
                mem[load_addr[IW-1:0]] <= load_data;
            end
            if (load_len_we) begin
                len_q <= len_d;
            end
        end
    end

    // Transport FSM with head position, tick counter and registered outputs.
    // A frame read is split in two: the tick edge moves pos and latches the
    // address, the following edge reads the RAM into photo and raises the strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dir_q     <= CMD_FWD;
            cnt_q     <= '0;
            pos_q     <= '0;
            rd_pend_q <= 1'b0;
            rd_addr_q <= '0;
            photo_q   <= '0;
            strobe_q  <= 1'b0;
            wft_q     <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            strobe_q  <= rd_pend_q;
            rd_pend_q <= 1'b0;
            if (rd_pend_q) begin
                photo_q <= mem[rd_addr_q];
            end

            case (state_q)
                S_IDLE: begin
                    if (cmd_d == CMD_FWD || cmd_d == CMD_REV) begin
                        state_q <= S_START;
                        dir_q   <= cmd_d;
                        cnt_q   <= '0;
                        wft_q   <= 1'b1;
                        run_q   <= 1'b1;
                    end else if (cmd_d == CMD_REWIND && pos_q != '0) begin
                        state_q <= S_REWIND;
                        cnt_q   <= '0;
                        run_q   <= 1'b1;
                    end
                end

                S_START: begin
                    if (cmd_d != dir_q) begin
                        state_q <= S_IDLE;
                        wft_q   <= 1'b0;
                        run_q   <= 1'b0;
                    end else if (tick_ms) begin
                        if (cnt_q == START_LAST) begin
                            cnt_q   <= '0;
                            state_q <= (dir_q == CMD_FWD) ? S_RUN_FWD : S_RUN_REV;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                S_RUN_FWD: begin
                    // A tick arriving together with a command drop is discarded.
                    if (cmd_d != CMD_FWD) begin
                        state_q <= S_IDLE;
                        wft_q   <= 1'b0;
                        run_q   <= 1'b0;
                    end else if (tick_ms) begin
                        if (cnt_q == FRAME_LAST) begin
                            cnt_q <= '0;
                            // At end of tape the motor keeps running but nothing is read.
                            if (pos_q < len_q) begin
                                rd_addr_q <= pos_q[IW-1:0];
                                rd_pend_q <= 1'b1;
                                pos_q     <= pos_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                S_RUN_REV: begin
                    if (cmd_d != CMD_REV) begin
                        state_q <= S_IDLE;
                        wft_q   <= 1'b0;
                        run_q   <= 1'b0;
                    end else if (tick_ms) begin
                        if (cnt_q == FRAME_LAST) begin
                            cnt_q <= '0;
                            // Reverse reads the frame the head has just moved back onto.
                            if (pos_q != '0) begin
                                rd_addr_q <= pos_dec[IW-1:0];
                                rd_pend_q <= 1'b1;
                                pos_q     <= pos_dec;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                S_REWIND: begin
                    if (cmd_d != CMD_REWIND || pos_q == '0) begin
                        state_q <= S_IDLE;
                        run_q   <= 1'b0;
                    end else if (tick_ms) begin
                        if (cnt_q == REWIND_LAST) begin
                            cnt_q <= '0;
                            pos_q <= pos_dec;
                            if (pos_dec == '0) begin
                                state_q <= S_IDLE;
                                run_q   <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    wft_q   <= 1'b0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign photo         = photo_q;
    assign frame_strobe  = strobe_q;
    assign wait_for_tape = wft_q;
    assign tape_run      = run_q;
    assign pos           = pos_q;
    assign at_bot        = (pos_q == '0);
    assign at_eot        = (pos_q == len_q);

endmodule

// File: tb/tb_photo_tape_transport.sv
module tb_photo_tape_transport;
    localparam int DATA_W    = 5;
    localparam int DEPTH     = 16;
    localparam int START_MS  = 10;
    localparam int FRAME_MS  = 4;
    localparam int REWIND_MS = 1;
    localparam int AW        = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              tick_ms;
    logic              load_we;
    logic [AW-1:0]     load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_len_we;
    logic [AW-1:0]     load_len;
    logic              fwd, rev, remote_rewind, sw_rewind, sw_forward;
    logic [DATA_W-1:0] photo;
    logic              frame_strobe, wait_for_tape, tape_run, at_bot, at_eot;
    logic [AW-1:0]     pos;

    photo_tape_transport #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .START_MS(START_MS),
        .FRAME_MS(FRAME_MS), .REWIND_MS(REWIND_MS)
    ) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .load_len_we(load_len_we), .load_len(load_len),
        .fwd(fwd), .rev(rev), .remote_rewind(remote_rewind),
        .sw_rewind(sw_rewind), .sw_forward(sw_forward),
        .photo(photo), .frame_strobe(frame_strobe),
        .wait_for_tape(wait_for_tape), .tape_run(tape_run),
        .at_bot(at_bot), .at_eot(at_eot), .pos(pos)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_strobe = 0;
    bit chk_en   = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model. Motion is described by total ticks since the motor
    // was started: frame k (k>=1) is due when ticks == START_MS + k*FRAME_MS.
    // Modes: 0 stopped, 1 forward, 2 reverse, 3 rewinding.
    int m_mode = 0;
    int m_ticks = 0;
    int m_pos = 0;
    int m_len = 0;
    int m_photo = 0;
    int m_paddr = 0;
    int m_cmd = 0;
    bit m_strobe = 0;
    bit m_pend = 0;
    bit m_len_known = 0;
    bit m_idle_now;
    int m_mem [DEPTH];

    always @(posedge clk) begin
        m_idle_now = (m_mode == 0);
        if (!rst && m_pend) m_photo = m_mem[m_paddr];
        if (m_idle_now) begin
            if (load_we && load_addr < DEPTH) m_mem[load_addr] = load_data;
            if (load_len_we) begin
                m_len = (load_len > DEPTH) ? DEPTH : load_len;
                m_len_known = 1;
            end
        end
        if (rst) begin
            m_mode = 0; m_pos = 0; m_photo = 0; m_strobe = 0; m_pend = 0;
        end else begin
            m_strobe = m_pend;
            m_pend = 0;
            if (remote_rewind || sw_rewind) m_cmd = 3;
            else if (fwd && rev)            m_cmd = 0;
            else if (rev)                   m_cmd = 2;
            else if (fwd || sw_forward)     m_cmd = 1;
            else                            m_cmd = 0;

            if (m_mode == 0) begin
                if (m_cmd == 1 || m_cmd == 2) begin
                    m_mode = m_cmd; m_ticks = 0;
                end else if (m_cmd == 3 && m_pos > 0) begin
                    m_mode = 3; m_ticks = 0;
                end
            end else if (m_cmd != m_mode) begin
                m_mode = 0;
            end else if (tick_ms) begin
                m_ticks++;
                if (m_mode == 3) begin
                    if (m_ticks % REWIND_MS == 0) begin
                        m_pos--;
                        if (m_pos == 0) m_mode = 0;
                    end
                end else if (m_ticks >= START_MS + FRAME_MS &&
                             (m_ticks - START_MS) % FRAME_MS == 0) begin
                    if (m_mode == 1 && m_pos < m_len) begin
                        m_paddr = m_pos; m_pos++; m_pend = 1;
                    end else if (m_mode == 2 && m_pos > 0) begin
                        m_pos--; m_paddr = m_pos; m_pend = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (frame_strobe === 1'b1) n_strobe++;
        if (chk_en) begin
            cmp("photo", 32'(photo), m_photo);
            cmp("frame_strobe", 32'(frame_strobe), 32'(m_strobe));
            cmp("wait_for_tape", 32'(wait_for_tape), 32'(m_mode == 1 || m_mode == 2));
            cmp("tape_run", 32'(tape_run), 32'(m_mode != 0));
            cmp("pos", 32'(pos), m_pos);
            cmp("at_bot", 32'(at_bot), 32'(m_pos == 0));
            if (m_len_known) cmp("at_eot", 32'(at_eot), 32'(m_pos == m_len));
        end
    end

    task automatic cyc(input bit t);
        tick_ms = t;
        @(negedge clk);
        #1;
        tick_ms = 1'b0;
    endtask

    // One ms tick every three clock cycles.
    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b1); cyc(1'b0); cyc(1'b0);
        end
    endtask

    task automatic set_cmd(input bit f, input bit r, input bit rr, input bit sr, input bit sf);
        fwd = f; rev = r; remote_rewind = rr; sw_rewind = sr; sw_forward = sf;
    endtask

    initial begin
        rst = 1'b1; tick_ms = 1'b0;
        load_we = 1'b0; load_addr = '0; load_data = '0;
        load_len_we = 1'b0; load_len = '0;
        set_cmd(0, 0, 0, 0, 0);
        repeat (3) cyc(1'b0);
        chk_en = 1'b1;
        cmp("rst_photo", 32'(photo), 0);
        cmp("rst_strobe", 32'(frame_strobe), 0);
        cmp("rst_wft", 32'(wait_for_tape), 0);
        cmp("rst_run", 32'(tape_run), 0);
        cmp("rst_pos", 32'(pos), 0);
        cmp("rst_at_bot", 32'(at_bot), 1);
        rst = 1'b0;

        // Tape image: frames 1..8, then filler for the rest of the RAM.
        for (int a = 0; a < DEPTH; a++) begin
            load_we = 1'b1; load_addr = AW'(a);
            load_data = (a < 8) ? DATA_W'(a + 1) : DATA_W'(16 + a);
            cyc(1'b0);
        end
        load_we = 1'b0;
        load_len_we = 1'b1; load_len = AW'(8);
        cyc(1'b0);
        load_len_we = 1'b0;
        cyc(1'b0);
        cmp("load_at_eot", 32'(at_eot), 0);

        // 1: forward run to end of tape
        set_cmd(1, 0, 0, 0, 0); cyc(1'b0);
        ticks(13);
        cmp("s1_no_early_strobe", n_strobe, 0);
        ticks(1);
        cmp("s1_first_strobe", n_strobe, 1);
        cmp("s1_first_photo", 32'(photo), 1);
        cmp("s1_first_pos", 32'(pos), 1);
        ticks(28);
        cmp("s1_strobes", n_strobe, 8);
        cmp("s1_last_photo", 32'(photo), 8);
        ticks(8);
        cmp("s1_eot_strobes", n_strobe, 8);
        cmp("s1_at_eot", 32'(at_eot), 1);
        cmp("s1_pos", 32'(pos), 8);
        cmp("s1_wft", 32'(wait_for_tape), 1);
        cmp("s1_run", 32'(tape_run), 1);

        // 2: reverse run from end of tape
        set_cmd(0, 0, 0, 0, 0); cyc(1'b0);
        set_cmd(0, 1, 0, 0, 0); cyc(1'b0);
        ticks(14);
        cmp("s2_first_photo", 32'(photo), 8);
        cmp("s2_first_pos", 32'(pos), 7);
        ticks(28);
        cmp("s2_strobes", n_strobe, 16);
        cmp("s2_last_photo", 32'(photo), 1);
        cmp("s2_at_bot", 32'(at_bot), 1);
        ticks(8);
        cmp("s2_bot_strobes", n_strobe, 16);

        // 3: rewind from pos 8
        set_cmd(0, 0, 0, 0, 0); cyc(1'b0);
        set_cmd(1, 0, 0, 0, 0); cyc(1'b0);
        ticks(42);
        cmp("s3_setup_pos", 32'(pos), 8);
        set_cmd(0, 0, 0, 0, 0); cyc(1'b0);
        set_cmd(0, 0, 0, 1, 0); cyc(1'b0);
        cmp("s3_run", 32'(tape_run), 1);
        cmp("s3_wft", 32'(wait_for_tape), 0);
        ticks(3);
        cmp("s3_pos_mid", 32'(pos), 5);
        ticks(5);
        cmp("s3_pos_end", 32'(pos), 0);
        cmp("s3_at_bot", 32'(at_bot), 1);
        cmp("s3_run_off", 32'(tape_run), 0);
        cmp("s3_no_strobes", n_strobe, 24);
        cmp("s3_photo_kept", 32'(photo), 8);

        // 4: priority and conflicts
        set_cmd(1, 0, 0, 0, 0); cyc(1'b0);
        ticks(18);
        cmp("s4_setup_pos", 32'(pos), 2);
        set_cmd(0, 0, 0, 0, 0); cyc(1'b0);
        set_cmd(0, 0, 1, 0, 1); cyc(1'b0);
        cmp("s4_rewind_wins_run", 32'(tape_run), 1);
        cmp("s4_rewind_wins_wft", 32'(wait_for_tape), 0);
        ticks(2);
        cmp("s4_rewound_pos", 32'(pos), 0);
        set_cmd(0, 0, 0, 0, 0); cyc(1'b0);
        set_cmd(1, 1, 0, 0, 0); cyc(1'b0); cyc(1'b0);
        cmp("s4_conflict_run", 32'(tape_run), 0);
        set_cmd(1, 0, 0, 0, 0); cyc(1'b0);
        ticks(2);
        load_we = 1'b1; load_addr = '0; load_data = 5'h1F;
        cyc(1'b0);
        load_we = 1'b0;
        ticks(12);
        cmp("s4_ram_unchanged", 32'(photo), 1);
        cmp("s4_strobes", n_strobe, 27);

        // 5: stop and restart
        ticks(8);
        cmp("s5_pos3", 32'(pos), 3);
        set_cmd(0, 0, 0, 0, 0); cyc(1'b0);
        cmp("s5_stop_run", 32'(tape_run), 0);
        cmp("s5_stop_pos", 32'(pos), 3);
        set_cmd(1, 0, 0, 0, 0); cyc(1'b0);
        ticks(13);
        cmp("s5_restart_wait", n_strobe, 29);
        ticks(1);
        cmp("s5_restart_photo", 32'(photo), 4);

        // 6: reset mid-run
        ticks(4);
        cmp("s6_setup_pos", 32'(pos), 5);
        rst = 1'b1; set_cmd(0, 0, 0, 0, 0); cyc(1'b0);
        cmp("s6_pos", 32'(pos), 0);
        cmp("s6_photo", 32'(photo), 0);
        cmp("s6_run", 32'(tape_run), 0);
        cmp("s6_wft", 32'(wait_for_tape), 0);
        rst = 1'b0;
        set_cmd(1, 0, 0, 0, 0); cyc(1'b0);
        ticks(14);
        cmp("s6_retained_photo", 32'(photo), 1);

        // Randomized phase against the model.
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 10))
                    0, 1, 2, 3: set_cmd(1, 0, 0, 0, 0);
                    4, 5:       set_cmd(0, 1, 0, 0, 0);
                    6:          set_cmd(0, 0, 0, 1, 0);
                    7:          set_cmd(0, 0, 1, 0, 1);
                    8:          set_cmd(1, 1, 0, 0, 0);
                    9:          set_cmd(0, 0, 0, 0, 1);
                    default:    set_cmd(0, 0, 0, 0, 0);
                endcase
            end
            tick_ms     = ($urandom_range(0, 2) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            load_we     = ($urandom_range(0, 19) == 0);
            load_addr   = AW'($urandom_range(0, 20));
            load_data   = DATA_W'($urandom);
            load_len_we = ($urandom_range(0, 79) == 0);
            load_len    = AW'($urandom_range(0, 20));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
